scan_select_gen: RTL and testbench

Upstream sequencer for the 2-to-4 case decoder. It generates the 2-bit select code `a` and the `enable` strobe that step the decoder through its four outputs in round-robin order. Each slot has a programmable dwell and a blanking gap, and slots whose mask bit is clear are skipped. Typical use is multiplexed 4-digit display scanning, where the decoder's one-hot `i[3:0]` drives the digit commons.

---
 rtl/scan_select_gen.sv | 124 ++++++++++++
 tb/tb_scan_select_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/scan_select_gen.sv
// scan_select_gen: round-robin select/enable sequencer for a 2-to-4 decoder.
// Each visited slot is BLANK cycles of enable=0 followed by PRESCALE cycles
// of enable=1. Slots whose mask bit is clear are skipped.
module scan_select_gen #(
    parameter int PRESCALE = 4,  // 1..255
    parameter int BLANK    = 1   // 0..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] mask,
    output logic [1:0] a,
    output logic       enable,
    output logic       frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ACTIVE} state_t;

    localparam logic [7:0] LP_PRE_LAST   = 8'(PRESCALE - 1);
    localparam logic [7:0] LP_BLANK_LAST = 8'((BLANK == 0) ? 0 : BLANK - 1);
    // With no blanking every slot starts directly in ACTIVE.
    localparam state_t     LP_START      = (BLANK == 0) ? S_ACTIVE : S_BLANK;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_a, w_a_nxt;
    logic       r_enable;
    logic       r_frame_done, w_fd_nxt;
    logic [1:0] w_first;
    logic [1:0] w_next;
    logic       w_wrap;

    // Lowest set index of mask (restart point after IDLE).
    always_comb begin
        w_first = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) w_first = 2'(i);
        end
    end

    // Next set index strictly after r_a, searching upward modulo 4.
    // Descending loop so the smallest offset wins; falls back to r_a for a
    // single-bit mask.
    always_comb begin
        w_next = r_a;
        for (int i = 3; i >= 1; i--) begin
            if (mask[r_a + 2'(i)]) w_next = r_a + 2'(i);
        end
        w_wrap = (w_next <= r_a);
    end

    // Next-state, dwell counter, slot select and frame pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_fd_nxt    = 1'b0;
        if (!run) begin
            // Stop wins over everything; a is held.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mask != 4'd0) begin
                        w_a_nxt     = w_first;
                        w_state_nxt = LP_START;
                        w_cnt_nxt   = 8'd0;
                    end
                end
                S_BLANK: begin
                    if (r_cnt == LP_BLANK_LAST) begin
                        w_state_nxt = S_ACTIVE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (r_cnt == LP_PRE_LAST) begin
                        // Slot boundary: mask is only looked at here.
                        w_cnt_nxt = 8'd0;
                        if (mask == 4'd0) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_a_nxt     = w_next;
                            w_fd_nxt    = w_wrap;
                            w_state_nxt = LP_START;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // State and registered outputs; enable is decoded from the next state so
    // it is a clean flop output aligned with ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_a          <= 2'd0;
            r_enable     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_a          <= w_a_nxt;
            r_enable     <= (w_state_nxt == S_ACTIVE);
            r_frame_done <= w_fd_nxt;
        end
    end

    assign a          = r_a;
    assign enable     = r_enable;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_select_gen.sv
// Directed bench for scan_select_gen: one instance with default blanking,
// one with BLANK=0.
module tb_scan_select_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, run0;
    logic [3:0] mask, mask0;
    logic [1:0] a, a0;
    logic       enable, enable0;
    logic       frame_done, frame_done0;

    int checks   = 0;
    int failures = 0;

    scan_select_gen #(.PRESCALE(4), .BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
        .a(a), .enable(enable), .frame_done(frame_done)
    );

    scan_select_gen #(.PRESCALE(4), .BLANK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0), .mask(mask0),
        .a(a0), .enable(enable0), .frame_done(frame_done0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE with mask m and check 'edges' cycles against the
    // slot model: 5 cycles per slot (1 blank + 4 active), slots in
    // ascending order of set mask bits, frame_done on each wrap.
    task automatic run_seq(input logic [3:0] m, input int edges);
        int idx[4];
        int n;
        int slot, ph;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                idx[n] = i;
                n++;
            end
        end
        mask = m;
        run  = 1'b1;
        for (int e = 1; e <= edges; e++) begin
            tick();
            slot = (e - 1) / 5;
            ph   = (e - 1) % 5;
            chk("seq_a",  8'(a),          8'(idx[slot % n]));
            chk("seq_en", 8'(enable),     8'(ph != 0));
            chk("seq_fd", 8'(frame_done), 8'(ph == 0 && slot > 0 && (slot % n) == 0));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        mask  = 4'd0;
        run0  = 1'b0;
        mask0 = 4'd0;

        // Reset state
        #3;
        chk("rst_a",    8'(a),           8'd0);
        chk("rst_en",   8'(enable),      8'd0);
        chk("rst_fd",   8'(frame_done),  8'd0);
        chk("rst_a0",   8'(a0),          8'd0);
        chk("rst_en0",  8'(enable0),     8'd0);
        chk("rst_fd0",  8'(frame_done0), 8'd0);
        #4 rst_n = 1'b1;
        tick();
        chk("idle_en",  8'(enable),      8'd0);
        chk("idle_a",   8'(a),           8'd0);

        // Full mask: 0,1,2,3 with wrap pulse every 20 cycles
        run_seq(4'b1111, 45);
        run = 1'b0;
        tick();
        chk("stop_full_en", 8'(enable),     8'd0);
        chk("stop_full_fd", 8'(frame_done), 8'd0);

        // Sparse mask: 0,2 alternating
        run_seq(4'b0101, 25);
        run = 1'b0;
        tick();
        chk("stop_sparse_en", 8'(enable), 8'd0);

        // Single bit: a stays 3, pulse every 5 cycles
        run_seq(4'b1000, 15);
        run = 1'b0;
        tick();
        chk("stop_single_en", 8'(enable), 8'd0);
        chk("stop_single_a",  8'(a),      8'd3);

        // Stop on 2nd ACTIVE cycle of slot 2, restart 3 cycles later
        run_seq(4'b1111, 13);
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halt_en", 8'(enable),     8'd0);
            chk("halt_a",  8'(a),          8'd2);
            chk("halt_fd", 8'(frame_done), 8'd0);
        end
        run = 1'b1;
        tick();
        chk("restart_a",    8'(a),          8'd0);
        chk("restart_en",   8'(enable),     8'd0);
        chk("restart_fd",   8'(frame_done), 8'd0);
        tick();
        chk("restart_en1",  8'(enable),     8'd1);
        chk("restart_a1",   8'(a),          8'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_a",    8'(a),          8'd1);
        chk("pre_rst_en",   8'(enable),     8'd1);

        // Asynchronous reset mid-ACTIVE, then release with no mask
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a",  8'(a),          8'd0);
        chk("arst_en", 8'(enable),     8'd0);
        chk("arst_fd", 8'(frame_done), 8'd0);
        mask = 4'd0;
        run  = 1'b1;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("nomask_en", 8'(enable), 8'd0);
            chk("nomask_a",  8'(a),      8'd0);
        end
        run = 1'b0;

        // BLANK=0: enable held high, mask 1111 -> 0011 in the middle of slot 1
        run0  = 1'b1;
        mask0 = 4'b1111;
        for (int e = 1; e <= 20; e++) begin
            int s;
            tick();
            chk("nb_en", 8'(enable0), 8'd1);
            if (e <= 8) begin
                chk("nb_a",  8'(a0),          8'((e - 1) / 4));
                chk("nb_fd", 8'(frame_done0), 8'd0);
            end else begin
                s = (e - 9) / 4;
                chk("nb_a",  8'(a0),          8'(s % 2));
                chk("nb_fd", 8'(frame_done0), 8'(((e - 9) % 4 == 0) && (s % 2 == 0)));
            end
            if (e == 6) mask0 = 4'b0011;
        end
        run0 = 1'b0;
        tick();
        chk("nb_stop_en", 8'(enable0), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
